seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised, registered successor to the combinational datapath ALU. Uses the same 5-bit opcode encodings.
- Single-cycle logic, shift and add ops. Multi-cycle signed multiply (radix-2 Booth) and signed divide (non-restoring).
- start/busy/done handshake, so the control unit can stall on long operations.
- Sits between the datapath Y/bus operands and the Z (hi/lo) register pair.

Parameters:
- WIDTH, 32, operand width. Must be a power of two, >= 8. C is 2*WIDTH.
- SHW, $clog2(WIDTH), number of B bits used as the shift/rotate amount.

Ports:
- clock, input, 1, rising-edge clock.
- clear, input, 1, asynchronous active-high reset.
- start, input, 1, request. Sampled only in IDLE.
- opcode, input, 5, operation select. Latched with start.
- A, input, WIDTH, operand A. Latched with start.
- B, input, WIDTH, operand B. Latched with start.
- C, output, 2*WIDTH, registered result: hi = C[2W-1:W], lo = C[W-1:0].
- busy, output, 1, high from the edge after start is accepted until the edge that asserts done.
- done, output, 1, one-cycle pulse in the cycle C is first valid.
- div_by_zero, output, 1, registered flag. Updated at every done.

Behaviour:
- Reset (clear=1, async): state=IDLE; C=0; busy=0; done=0; div_by_zero=0. Asserting clear mid-operation aborts it; no done is produced.
- Opcodes:
  - add=00011, sub=00100, and=00101, or=00110, ror=00111, rol=01000
  - shr=01001, shra=01010, shl=01011, xor=01101, nor=01110, div=01111
  - mul=10000, neg=10001, not=10010, nop=11010
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - start=1 with mul → MUL, counter=WIDTH.
  - start=1 with div and B!=0 → DIV, counter=WIDTH.
  - Any other opcode, or div with B=0 → compute in one cycle and go to DONE.
- MUL/DIV:
  - One Booth / non-restoring step per cycle; counter decrements.
  - At counter==1, go to DIV fixup (div) or directly to DONE.
- DONE:
  - C and div_by_zero are written at the entry edge. done=1 and busy=0 for this one cycle.
  - Then → IDLE. A start seen in this cycle is ignored.
- Latency, measured from the start-sampling edge to the edge that asserts done:
  - Single-cycle ops: 1.
  - mul: WIDTH+1.
  - div: WIDTH+2 (one sign-fixup cycle).
- start while busy or in DONE: ignored. Live A/B/opcode changes during an operation have no effect.
- Width rules:
  - add/sub: lo = A±B mod 2^W; hi = sign-extension of lo[W-1]; carry discarded.
  - and/or/xor/nor/not(~A)/neg(-A): hi = 0.
  - shl/shr/shra/rol/ror: amount = B[SHW-1:0] (upper B bits ignored); hi = 0. shra replicates A[W-1].
  - mul: C = signed A × signed B, full 2W bits.
  - div (dividend A, divisor B, signed, truncate toward zero):
    - lo = quotient, hi = remainder. Remainder carries the dividend's sign.
    - A = MIN, B = -1 → lo = MIN, hi = 0, div_by_zero = 0.
    - B = 0 → lo = all ones, hi = A, div_by_zero = 1.
  - nop and undefined opcodes: C unchanged; done still pulses after 1 cycle; div_by_zero cleared.
- C holds its value between operations.

Test Plan:
- WIDTH=32, add A=0x7FFFFFFF B=1 → next edge: C=0xFFFFFFFF_80000000, done=1 for one cycle, busy never high.
- mul A=-3 B=7 → busy high 32 cycles; on edge 33: C=0xFFFFFFFF_FFFFFFEB, done pulse. Repeat with A=0x80000000 B=0x80000000 → C=0x40000000_00000000.
- div A=-7 B=2 → edge 34: lo=0xFFFFFFFD, hi=0xFFFFFFFF, div_by_zero=0. Then div A=5 B=0 → edge 1: lo=0xFFFFFFFF, hi=5, div_by_zero=1.
- ror A=0x80000001 B=33 → C=0x00000000_C0000000. shra A=0x80000000 B=4 → lo=0xF8000000.
- Handshake: during a mul, pulse start with add and change A/B every cycle → ignored; mul result unchanged; exactly one done.
- clear asserted mid-div at cycle 10 (async, between edges) → C=0, busy=0 immediately; no done. A following add 2+3 → C=5.

Source files
------------

// File: rtl/seq_alu.sv
// Registered ALU with single-cycle logic/shift/add ops, radix-2 Booth multiply and
// non-restoring signed divide behind a start/busy/done handshake.
module seq_alu #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               start,
  input  logic [4:0]         opcode,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] C,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero
);

  localparam logic [4:0] OpAdd  = 5'b00011;
  localparam logic [4:0] OpSub  = 5'b00100;
  localparam logic [4:0] OpAnd  = 5'b00101;
  localparam logic [4:0] OpOr   = 5'b00110;
  localparam logic [4:0] OpRor  = 5'b00111;
  localparam logic [4:0] OpRol  = 5'b01000;
  localparam logic [4:0] OpShr  = 5'b01001;
  localparam logic [4:0] OpShra = 5'b01010;
  localparam logic [4:0] OpShl  = 5'b01011;
  localparam logic [4:0] OpXor  = 5'b01101;
  localparam logic [4:0] OpNor  = 5'b01110;
  localparam logic [4:0] OpDiv  = 5'b01111;
  localparam logic [4:0] OpMul  = 5'b10000;
  localparam logic [4:0] OpNeg  = 5'b10001;
  localparam logic [4:0] OpNot  = 5'b10010;

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CntInit = CW'(WIDTH);
  localparam logic [CW-1:0] CntOne  = CW'(1);

  typedef enum logic [2:0] {StIdle, StMul, StDiv, StFix, StDone} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  // Two guard bits: Booth accumulator may need W+1 bits (MIN operand), divider
  // partial remainder spans [-2D, 2D).
  logic [WIDTH+1:0]   acc_q, acc_d;
  logic [WIDTH+1:0]   m_q, m_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               qm1_q, qm1_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic [2*WIDTH-1:0] c_q, c_d;
  logic               dbz_q, dbz_d;

  // Single-cycle result path, driven from the live operands in IDLE.
  logic [SHW-1:0]   amt;
  logic [WIDTH-1:0] sc_lo, sc_hi;
  logic             sc_dbz;

  always_comb begin
    amt    = B[SHW-1:0];
    sc_lo  = c_q[WIDTH-1:0];
    sc_hi  = c_q[2*WIDTH-1:WIDTH];
    sc_dbz = 1'b0;
    case (opcode)
      OpAdd: begin
        sc_lo = A + B;
        sc_hi = {WIDTH{sc_lo[WIDTH-1]}};
      end
      OpSub: begin
        sc_lo = A - B;
        sc_hi = {WIDTH{sc_lo[WIDTH-1]}};
      end
      OpAnd:  begin sc_lo = A & B;    sc_hi = '0; end
      OpOr:   begin sc_lo = A | B;    sc_hi = '0; end
      OpXor:  begin sc_lo = A ^ B;    sc_hi = '0; end
      OpNor:  begin sc_lo = ~(A | B); sc_hi = '0; end
      OpNot:  begin sc_lo = ~A;       sc_hi = '0; end
      OpNeg:  begin sc_lo = -A;       sc_hi = '0; end
      OpShl:  begin sc_lo = A << amt; sc_hi = '0; end
      OpShr:  begin sc_lo = A >> amt; sc_hi = '0; end
      OpShra: begin sc_lo = $signed(A) >>> amt; sc_hi = '0; end
      OpRor:  begin sc_lo = WIDTH'({A, A} >> amt); sc_hi = '0; end
      OpRol:  begin sc_lo = WIDTH'(({A, A} << amt) >> WIDTH); sc_hi = '0; end
      OpDiv: begin
        // Only reached with B == 0; nonzero divisors take the iterative path.
        sc_lo  = '1;
        sc_hi  = A;
        sc_dbz = 1'b1;
      end
      default: ;
    endcase
  end

  // Iterative datapath: one Booth step and one non-restoring step per cycle.
  logic [WIDTH+1:0] mul_sum, mul_acc;
  logic [WIDTH-1:0] mul_q;
  logic [WIDTH+1:0] div_shift, div_acc;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH-1:0] rem_mag, rem_fix, quo_fix;

  always_comb begin
    case ({q_q[0], qm1_q})
      2'b01:   mul_sum = acc_q + m_q;
      2'b10:   mul_sum = acc_q - m_q;
      default: mul_sum = acc_q;
    endcase
    mul_acc = {mul_sum[WIDTH+1], mul_sum[WIDTH+1:1]};
    mul_q   = {mul_sum[0], q_q[WIDTH-1:1]};

    div_shift = {acc_q[WIDTH:0], q_q[WIDTH-1]};
    div_acc   = acc_q[WIDTH+1] ? div_shift + m_q : div_shift - m_q;
    div_q     = {q_q[WIDTH-2:0], ~div_acc[WIDTH+1]};

    abs_a = A[WIDTH-1] ? -A : A;
    abs_b = B[WIDTH-1] ? -B : B;

    rem_mag = WIDTH'(acc_q[WIDTH+1] ? acc_q + m_q : acc_q);
    rem_fix = neg_rem_q ? -rem_mag : rem_mag;
    quo_fix = neg_quo_q ? -q_q : q_q;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    m_d       = m_q;
    q_d       = q_q;
    qm1_d     = qm1_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    c_d       = c_q;
    dbz_d     = dbz_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (opcode == OpMul) begin
            state_d = StMul;
            cnt_d   = CntInit;
            acc_d   = '0;
            m_d     = {{2{A[WIDTH-1]}}, A};
            q_d     = B;
            qm1_d   = 1'b0;
          end else if (opcode == OpDiv && B != '0) begin
            state_d   = StDiv;
            cnt_d     = CntInit;
            acc_d     = '0;
            m_d       = {2'b00, abs_b};
            q_d       = abs_a;
            neg_quo_d = A[WIDTH-1] ^ B[WIDTH-1];
            neg_rem_d = A[WIDTH-1];
          end else begin
            state_d = StDone;
            c_d     = {sc_hi, sc_lo};
            dbz_d   = sc_dbz;
          end
        end
      end
      StMul: begin
        cnt_d = cnt_q - CntOne;
        acc_d = mul_acc;
        q_d   = mul_q;
        qm1_d = q_q[0];
        if (cnt_q == CntOne) begin
          state_d = StDone;
          c_d     = {mul_acc[WIDTH-1:0], mul_q};
          dbz_d   = 1'b0;
        end
      end
      StDiv: begin
        cnt_d = cnt_q - CntOne;
        acc_d = div_acc;
        q_d   = div_q;
        if (cnt_q == CntOne) state_d = StFix;
      end
      StFix: begin
        state_d = StDone;
        c_d     = {rem_fix, quo_fix};
        dbz_d   = 1'b0;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      acc_q     <= '0;
      m_q       <= '0;
      q_q       <= '0;
      qm1_q     <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      c_q       <= '0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      m_q       <= m_d;
      q_q       <= q_d;
      qm1_q     <= qm1_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      c_q       <= c_d;
      dbz_q     <= dbz_d;
    end
  end

  assign C           = c_q;
  assign busy        = (state_q == StMul) || (state_q == StDiv) || (state_q == StFix);
  assign done        = (state_q == StDone);
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed, table-driven bench for seq_alu at WIDTH=32: result, flag, latency,
// busy duration and done pulse width per op, plus handshake and abort sequences.
module tb_seq_alu;

  localparam logic [4:0] OpAdd  = 5'b00011;
  localparam logic [4:0] OpSub  = 5'b00100;
  localparam logic [4:0] OpAnd  = 5'b00101;
  localparam logic [4:0] OpOr   = 5'b00110;
  localparam logic [4:0] OpRor  = 5'b00111;
  localparam logic [4:0] OpRol  = 5'b01000;
  localparam logic [4:0] OpShr  = 5'b01001;
  localparam logic [4:0] OpShra = 5'b01010;
  localparam logic [4:0] OpShl  = 5'b01011;
  localparam logic [4:0] OpXor  = 5'b01101;
  localparam logic [4:0] OpNor  = 5'b01110;
  localparam logic [4:0] OpDiv  = 5'b01111;
  localparam logic [4:0] OpMul  = 5'b10000;
  localparam logic [4:0] OpNeg  = 5'b10001;
  localparam logic [4:0] OpNot  = 5'b10010;
  localparam logic [4:0] OpNop  = 5'b11010;
  localparam logic [4:0] OpUndef = 5'b00000;

  logic        clock = 1'b0;
  logic        clear;
  logic        start;
  logic [4:0]  opcode;
  logic [31:0] a_val, b_val;
  logic [63:0] c_val;
  logic        busy, done, div_by_zero;

  int errors = 0;
  int checks = 0;

  seq_alu #(.WIDTH(32)) dut (
    .clock       (clock),
    .clear       (clear),
    .start       (start),
    .opcode      (opcode),
    .A           (a_val),
    .B           (b_val),
    .C           (c_val),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] c;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] c, input logic dbz, input int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.c = c; v.dbz = dbz; v.lat = lat;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issue one op and check result, flag, latency, busy duration and done width.
  task automatic run_op(input string name, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp_c, input logic exp_dbz,
                        input int exp_lat);
    int lat = 0;
    int busy_cnt = 0;
    bit seen = 0;
    opcode = op; a_val = a; b_val = b; start = 1'b1;
    while (!seen && lat < 100) begin
      @(posedge clock); #1;
      lat++;
      start = 1'b0;
      a_val = ~a;
      b_val = ~b;
      if (done) seen = 1;
      else if (busy) busy_cnt++;
    end
    check({name, " done seen"}, 64'(seen), 64'd1);
    check({name, " C"}, c_val, exp_c);
    check({name, " div_by_zero"}, 64'(div_by_zero), 64'(exp_dbz));
    check({name, " latency"}, 64'(lat), 64'(exp_lat));
    check({name, " busy cycles"}, 64'(busy_cnt), 64'(exp_lat - 1));
    check({name, " busy at done"}, 64'(busy), 64'd0);
    @(posedge clock); #1;
    check({name, " done width"}, 64'(done), 64'd0);
    check({name, " C held"}, c_val, exp_c);
  endtask

  initial begin
    int done_cnt;
    int done_lat;
    logic [63:0] c_at_done;

    add_vec(OpAdd,  32'h7FFF_FFFF, 32'h0000_0001, 64'hFFFF_FFFF_8000_0000, 1'b0, 1);
    add_vec(OpSub,  32'h0000_0005, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1);
    add_vec(OpAnd,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 64'h0000_0000_00F0_00F0, 1'b0, 1);
    add_vec(OpOr,   32'hF000_0000, 32'h0000_000F, 64'h0000_0000_F000_000F, 1'b0, 1);
    add_vec(OpXor,  32'hFFFF_0000, 32'h0F0F_0F0F, 64'h0000_0000_F0F0_0F0F, 1'b0, 1);
    add_vec(OpNor,  32'hF0F0_F0F0, 32'h0F0F_0000, 64'h0000_0000_0000_0F0F, 1'b0, 1);
    add_vec(OpNot,  32'h1234_5678, 32'h0000_0000, 64'h0000_0000_EDCB_A987, 1'b0, 1);
    add_vec(OpNeg,  32'h0000_0005, 32'h0000_0000, 64'h0000_0000_FFFF_FFFB, 1'b0, 1);
    add_vec(OpRor,  32'h8000_0001, 32'd33,        64'h0000_0000_C000_0000, 1'b0, 1);
    add_vec(OpRol,  32'h8000_0001, 32'd4,         64'h0000_0000_0000_0018, 1'b0, 1);
    add_vec(OpShr,  32'h8000_0000, 32'd36,        64'h0000_0000_0800_0000, 1'b0, 1);
    add_vec(OpShra, 32'h8000_0000, 32'd4,         64'h0000_0000_F800_0000, 1'b0, 1);
    add_vec(OpShl,  32'h0000_0003, 32'hFFFF_FFE1, 64'h0000_0000_0000_0006, 1'b0, 1);
    add_vec(OpMul,  32'hFFFF_FFFD, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0, 33);
    add_vec(OpMul,  32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0, 33);
    add_vec(OpMul,  32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, 1'b0, 33);
    add_vec(OpDiv,  32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 34);
    add_vec(OpDiv,  32'h0000_0005, 32'h0000_0000, 64'h0000_0005_FFFF_FFFF, 1'b1, 1);
    add_vec(OpNop,  32'h1111_1111, 32'h2222_2222, 64'h0000_0005_FFFF_FFFF, 1'b0, 1);
    add_vec(OpDiv,  32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0, 34);
    add_vec(OpDiv,  32'd100,       32'hFFFF_FFF9, 64'h0000_0002_FFFF_FFF2, 1'b0, 34);
    add_vec(OpUndef, 32'hDEAD_BEEF, 32'h1,        64'h0000_0002_FFFF_FFF2, 1'b0, 1);

    clear = 1'b1; start = 1'b0; opcode = OpNop; a_val = '0; b_val = '0;
    repeat (2) @(posedge clock);
    #1;
    check("reset C", c_val, 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset div_by_zero", 64'(div_by_zero), 64'd0);
    clear = 1'b0;
    @(posedge clock); #1;

    foreach (vecs[i])
      run_op($sformatf("vec%0d op%05b", i, vecs[i].op), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].c, vecs[i].dbz, vecs[i].lat);

    // Handshake: start pulses with add and changing operands during a mul are ignored,
    // including the one held through the DONE cycle.
    opcode = OpMul; a_val = 32'hFFFF_FFFD; b_val = 32'h0000_0007; start = 1'b1;
    done_cnt = 0; done_lat = 0; c_at_done = '0;
    for (int cyc = 1; cyc <= 45; cyc++) begin
      @(posedge clock); #1;
      if (done) begin
        done_cnt++;
        if (done_cnt == 1) begin
          done_lat  = cyc;
          c_at_done = c_val;
        end
      end
      if (done_cnt == 0 || (done_cnt == 1 && done)) begin
        start  = 1'b1;
        opcode = OpAdd;
        a_val  = $urandom;
        b_val  = $urandom;
      end else begin
        start = 1'b0;
      end
    end
    check("handshake done count", 64'(done_cnt), 64'd1);
    check("handshake latency", 64'(done_lat), 64'd33);
    check("handshake C", c_at_done, 64'hFFFF_FFFF_FFFF_FFEB);
    check("handshake C after", c_val, 64'hFFFF_FFFF_FFFF_FFEB);

    // Abort: clear mid-divide, between edges.
    opcode = OpDiv; a_val = 32'd100; b_val = 32'd7; start = 1'b1;
    repeat (10) begin
      @(posedge clock); #1;
      start = 1'b0;
    end
    check("abort busy before clear", 64'(busy), 64'd1);
    #3 clear = 1'b1;
    #1;
    check("abort C", c_val, 64'd0);
    check("abort busy", 64'(busy), 64'd0);
    check("abort done", 64'(done), 64'd0);
    @(posedge clock); #1;
    clear = 1'b0;
    done_cnt = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (done) done_cnt++;
    end
    check("abort no done", 64'(done_cnt), 64'd0);
    check("abort C still zero", c_val, 64'd0);

    run_op("post-abort add", OpAdd, 32'd2, 32'd3, 64'd5, 1'b0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
